// File: rtl/mag_sequencer.sv
// Tile sequencer for the gradient-magnitude datapath.
// Walks a frame tile by tile: accept, compute (with timeout), hand off.
module mag_sequencer #(
  parameter int unsigned NUM_TILES = 4096,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        frame_start,
  input  logic        grad_valid,
  output logic        grad_ready,
  output logic        tile_load,
  output logic        mag_en,
  input  logic        mag_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] tile_addr,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    RUN,
    OUT,
    DONE,
    ERR
  } state_e;

  localparam logic [11:0] LAST = 12'(NUM_TILES - 1);
  localparam logic [7:0]  TMAX = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  timer_q, timer_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          addr_d  = '0;
          state_d = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (grad_valid) begin
          timer_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        timer_d = timer_q + 8'd1;
        // a completion arriving on the last allowed cycle still counts
        if (mag_done) begin
          state_d = OUT;
        end else if (timer_q == TMAX) begin
          state_d = ERR;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (addr_q == LAST) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 12'd1;
            state_d = WAIT_IN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        if (frame_start) begin
          addr_d  = '0;
          state_d = WAIT_IN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grad_ready = (state_q == WAIT_IN);
  assign tile_load  = (state_q == WAIT_IN) && grad_valid;
  assign mag_en     = (state_q == RUN);
  assign out_valid  = (state_q == OUT);
  assign busy       = (state_q != IDLE) && (state_q != ERR);
  assign frame_done = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign tile_addr  = addr_q;

endmodule

// File: tb/tb_mag_sequencer.sv
// Directed bench for mag_sequencer (NUM_TILES=4, TIMEOUT=8).
// Flags vector: {grad_ready,tile_load,mag_en,out_valid,busy,frame_done,err}.
module tb_mag_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        frame_start;
  logic        grad_valid;
  logic        grad_ready;
  logic        tile_load;
  logic        mag_en;
  logic        mag_done;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] tile_addr;
  logic        busy;
  logic        frame_done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;

  localparam logic [6:0] F_IDLE  = 7'b0000000;
  localparam logic [6:0] F_WAIT  = 7'b1000100;
  localparam logic [6:0] F_WAITL = 7'b1100100;
  localparam logic [6:0] F_RUN   = 7'b0010100;
  localparam logic [6:0] F_OUT   = 7'b0001100;
  localparam logic [6:0] F_DONE  = 7'b0000110;
  localparam logic [6:0] F_ERR   = 7'b0000001;

  mag_sequencer #(
    .NUM_TILES(4),
    .TIMEOUT  (8)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .frame_start(frame_start),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .tile_load  (tile_load),
    .mag_en     (mag_en),
    .mag_done   (mag_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .tile_addr  (tile_addr),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] ef,
                     input logic [11:0] ea);
    logic [6:0] of;
    of = {grad_ready, tile_load, mag_en, out_valid, busy, frame_done, err};
    n_cmp++;
    assert ({of, tile_addr} === {ef, ea}) else begin
      n_bad++;
      $error("FAIL %s: flags=%b addr=%0d expected flags=%b addr=%0d",
             tag, of, tile_addr, ef, ea);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, o, e);
    end
  endtask

  initial begin
    n_rst       = 1'b0;
    frame_start = 1'b0;
    grad_valid  = 1'b0;
    mag_done    = 1'b0;
    out_ready   = 1'b0;
    #3;
    chk("reset", F_IDLE, 12'd0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    chk("idle", F_IDLE, 12'd0);

    // full frame of 4 tiles, grad_valid held high
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("start_wait", F_WAIT, 12'd0);
    grad_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("load", F_WAITL, 12'(i));
      tick();
      chk("run1", F_RUN, 12'(i));
      tick();
      mag_done = 1'b1;
      tick();
      mag_done = 1'b0;
      chk("out", F_OUT, 12'(i));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (i < 3) chk("next_wait", F_WAITL, 12'(i + 1));
    end
    grad_valid = 1'b0;
    chk("done", F_DONE, 12'd3);
    tick();
    chk("after_done", F_IDLE, 12'd3);
    chk_int("frame_done_cnt", fd_cnt, 1);

    // timeout: 8 RUN cycles without mag_done
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    grad_valid = 1'b1;
    tick();
    grad_valid = 1'b0;
    chk("to_run1", F_RUN, 12'd0);
    for (int k = 2; k <= 8; k++) tick();
    chk("to_run8", F_RUN, 12'd0);
    tick();
    chk("timeout_err", F_ERR, 12'd0);
    tick();
    chk("err_sticky", F_ERR, 12'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("err_clear", F_WAIT, 12'd0);

    // mag_done on the 8th RUN cycle beats the timeout
    grad_valid = 1'b1;
    tick();
    grad_valid = 1'b0;
    for (int k = 2; k <= 8; k++) tick();
    chk("edge_run8", F_RUN, 12'd0);
    mag_done = 1'b1;
    tick();
    mag_done = 1'b0;
    chk("edge_out", F_OUT, 12'd0);

    // back-pressure for 5 cycles
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold", F_OUT, 12'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", F_WAIT, 12'd1);

    // ignored frame_start / mag_done
    mag_done = 1'b1;
    tick();
    mag_done = 1'b0;
    chk("ign_done_wait", F_WAIT, 12'd1);
    grad_valid = 1'b1;
    tick();
    grad_valid = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ign_fs_run", F_RUN, 12'd1);
    mag_done = 1'b1;
    tick();
    mag_done = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ign_fs_out", F_OUT, 12'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("wait_t2", F_WAIT, 12'd2);

    // reset during RUN of tile 2
    grad_valid = 1'b1;
    tick();
    grad_valid = 1'b0;
    chk("run_t2", F_RUN, 12'd2);
    n_rst = 1'b0;
    #1;
    chk("mid_reset", F_IDLE, 12'd0);
    tick();
    n_rst = 1'b1;
    tick();
    chk("post_reset", F_IDLE, 12'd0);
    tick();
    chk_int("no_extra_fd", fd_cnt, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("restart", F_WAIT, 12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
